// File: rtl/sram_request_sequencer_if.sv
// Request, controller and response signals of the SRAM request sequencer.
// The slave modport is the sequencer's view; the master modport is the view
// of whatever drives requests and models the controller.
interface sram_request_sequencer_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int LEVEL_WIDTH = 3
);
  logic                   iReqValid;
  logic                   oReqReady;
  logic                   iReqWrite;
  logic [ADDR_WIDTH-1:0]  iReqAddr;
  logic [DATA_WIDTH-1:0]  iReqData;
  logic                   oTrigger;
  logic                   oReadSel;
  logic [ADDR_WIDTH-1:0]  oAddress;
  logic [DATA_WIDTH-1:0]  oDataOut;
  logic [DATA_WIDTH-1:0]  iReadData;
  logic                   oRspValid;
  logic [DATA_WIDTH-1:0]  oRspData;
  logic                   oBusy;
  logic [LEVEL_WIDTH-1:0] oLevel;

  modport slave (
    input  iReqValid, iReqWrite, iReqAddr, iReqData, iReadData,
    output oReqReady, oTrigger, oReadSel, oAddress, oDataOut,
           oRspValid, oRspData, oBusy, oLevel
  );

  modport master (
    output iReqValid, iReqWrite, iReqAddr, iReqData, iReadData,
    input  oReqReady, oTrigger, oReadSel, oAddress, oDataOut,
           oRspValid, oRspData, oBusy, oLevel
  );
endinterface

// File: rtl/sram_request_sequencer.sv
// SRAM request sequencer: buffers read/write requests in a small FIFO and
// issues them one at a time to the SRAM controller, timing each access with
// a down-counter and returning read data on a one-cycle response strobe.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no access in flight; pops the FIFO head when non-empty
//   ST_ISSUE | trigger pulse to the controller; loads the wait counter
//   ST_WAIT  | counting out the access time; read data captured at the end
module sram_request_sequencer #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int WRITE_CYCLES = 4,
  parameter int READ_CYCLES  = 3
) (
  input logic                     Clock,
  input logic                     Reset,
  sram_request_sequencer_if.slave bus
);

  localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int LEVEL_WIDTH = $clog2(FIFO_DEPTH) + 1;
  localparam int MAX_CYCLES  = (WRITE_CYCLES > READ_CYCLES) ? WRITE_CYCLES : READ_CYCLES;
  localparam int CNT_WIDTH   = $clog2(MAX_CYCLES) + 1;
  localparam int ENTRY_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0]   CNT_WRITE  = CNT_WIDTH'(WRITE_CYCLES);
  localparam logic [CNT_WIDTH-1:0]   CNT_READ   = CNT_WIDTH'(READ_CYCLES);
  localparam logic [CNT_WIDTH-1:0]   CNT_LAST   = CNT_WIDTH'(1);

  logic [ENTRY_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]   r_wr_ptr;
  logic [PTR_WIDTH-1:0]   r_rd_ptr;
  logic [LEVEL_WIDTH-1:0] r_count;
  logic [LEVEL_WIDTH-1:0] r_level;
  logic                   r_ready;

  logic [1:0]             r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_trigger;
  logic                   r_read_sel;
  logic [ADDR_WIDTH-1:0]  r_address;
  logic [DATA_WIDTH-1:0]  r_data_out;
  logic                   r_rsp_valid;
  logic [DATA_WIDTH-1:0]  r_rsp_data;

  logic                   w_push;
  logic                   w_pop;
  logic [LEVEL_WIDTH-1:0] w_count_next;
  logic [ENTRY_WIDTH-1:0] w_head;
  logic                   w_head_write;
  logic [ADDR_WIDTH-1:0]  w_head_addr;
  logic [DATA_WIDTH-1:0]  w_head_data;

  // Ready is registered, so a push can only ever land on a free slot.
  assign w_push = bus.iReqValid & r_ready;
  assign w_pop  = (r_state == ST_IDLE) && (r_count != '0);

  assign w_head = r_mem[r_rd_ptr];
  assign {w_head_write, w_head_addr, w_head_data} = w_head;

  // Occupancy after this edge; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)
      w_count_next = r_count + LEVEL_WIDTH'(1);
    else if (!w_push && w_pop)
      w_count_next = r_count - LEVEL_WIDTH'(1);
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge Clock) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {bus.iReqWrite, bus.iReqAddr, bus.iReqData};
  end

  // FIFO pointers, count and the registered ready/level views of the count.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_level  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
      r_count <= w_count_next;
      r_level <= w_count_next;
      r_ready <= (w_count_next != FULL_LEVEL);
    end
  end

  // Access sequencing: pop, trigger, count out the access, return read data.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_trigger   <= 1'b0;
      r_read_sel  <= 1'b0;
      r_address   <= '0;
      r_data_out  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_trigger   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_address  <= w_head_addr;
            r_data_out <= w_head_data;
            r_read_sel <= ~w_head_write;
            r_trigger  <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= r_read_sel ? CNT_READ : CNT_WRITE;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - CNT_WIDTH'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            if (r_read_sel) begin
              r_rsp_data  <= bus.iReadData;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.oReqReady = r_ready;
  assign bus.oLevel    = r_level;
  assign bus.oTrigger  = r_trigger;
  assign bus.oReadSel  = r_read_sel;
  assign bus.oAddress  = r_address;
  assign bus.oDataOut  = r_data_out;
  assign bus.oRspValid = r_rsp_valid;
  assign bus.oRspData  = r_rsp_data;
  assign bus.oBusy     = (r_state != ST_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_sram_request_sequencer.sv
// Testbench for sram_request_sequencer: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a transaction-level
// reference model (request queue plus access-completion schedule).
module tb_sram_request_sequencer;

  localparam int DEPTH = 4;
  localparam int WCYC  = 4;
  localparam int RCYC  = 3;

  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  sram_request_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .LEVEL_WIDTH(3)) bus ();

  sram_request_sequencer #(
    .DATA_WIDTH(16), .ADDR_WIDTH(8), .FIFO_DEPTH(DEPTH),
    .WRITE_CYCLES(WCYC), .READ_CYCLES(RCYC)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus)
  );

  typedef struct {
    bit          wr;
    logic [7:0]  a;
    logic [15:0] d;
  } req_t;

  typedef struct {
    bit          wr;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] rd;
    int          e_trig;
    bit          e_rs;
    int          e_rsp;
    int          e_idle;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model state
  req_t        mq[$];
  int          t;
  int          next_free, trig_c, rsp_c, cap_c;
  logic        e_rs;
  logic [7:0]  e_a;
  logic [15:0] e_d, e_rd;
  bit          model_en;
  bit          last_push;

  // values sampled in the most recent step
  logic        s_trig, s_rsp, s_busy, s_ready, s_rs;
  logic [2:0]  s_level;
  logic [7:0]  s_addr;
  logic [15:0] s_dout, s_rdata;
  int          trig_t[$];
  logic [7:0]  trig_a[$];
  logic        trig_rs[$];
  int          rsp_t[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, t);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    next_free = 0;
    trig_c    = -1;
    rsp_c     = -1;
    cap_c     = -1;
    e_rs      = 1'b0;
    e_a       = '0;
    e_d       = '0;
    e_rd      = '0;
    last_push = 1'b0;
  endfunction

  // One clock cycle: compare at the falling edge, advance the model, then
  // move to just after the rising edge where the caller changes inputs.
  task automatic step();
    req_t r;
    bit   push;
    int   c;
    @(negedge Clock);
    s_trig  = bus.oTrigger;
    s_rsp   = bus.oRspValid;
    s_busy  = bus.oBusy;
    s_ready = bus.oReqReady;
    s_level = bus.oLevel;
    s_addr  = bus.oAddress;
    s_dout  = bus.oDataOut;
    s_rdata = bus.oRspData;
    s_rs    = bus.oReadSel;
    if (s_trig) begin
      trig_t.push_back(t);
      trig_a.push_back(s_addr);
      trig_rs.push_back(s_rs);
    end
    if (s_rsp) rsp_t.push_back(t);
    if (model_en) begin
      chk("level",    32'(s_level), 32'(mq.size()));
      chk("ready",    32'(s_ready), 32'(mq.size() < DEPTH));
      chk("busy",     32'(s_busy),  32'((mq.size() > 0) || (t < next_free)));
      chk("trigger",  32'(s_trig),  32'(t == trig_c));
      chk("rspvalid", 32'(s_rsp),   32'(t == rsp_c));
      chk("readsel",  32'(s_rs),    32'(e_rs));
      chk("address",  32'(s_addr),  32'(e_a));
      chk("dataout",  32'(s_dout),  32'(e_d));
      chk("rspdata",  32'(s_rdata), 32'(e_rd));
      if (t == cap_c) e_rd = bus.iReadData;
      push = bus.iReqValid && (mq.size() < DEPTH);
      if ((t >= next_free) && (mq.size() > 0)) begin
        r         = mq.pop_front();
        e_rs      = !r.wr;
        e_a       = r.a;
        e_d       = r.d;
        c         = r.wr ? WCYC : RCYC;
        trig_c    = t + 1;
        next_free = t + c + 2;
        if (!r.wr) begin
          cap_c = t + c + 1;
          rsp_c = t + c + 2;
        end
      end
      if (push) begin
        r.wr = bus.iReqWrite;
        r.a  = bus.iReqAddr;
        r.d  = bus.iReqData;
        mq.push_back(r);
      end
      last_push = push;
    end
    @(posedge Clock);
    #1;
    t++;
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic push_req(input bit wr, input logic [7:0] a, input logic [15:0] d);
    int guard;
    bus.iReqValid = 1'b1;
    bus.iReqWrite = wr;
    bus.iReqAddr  = a;
    bus.iReqData  = d;
    step();
    guard = 0;
    while (!last_push && guard < 60) begin
      step();
      guard++;
    end
    if (!last_push) chk("push_timeout", 32'd1, 32'd0);
    bus.iReqValid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    step();
    while (s_busy && guard < 100) begin
      step();
      guard++;
    end
    if (s_busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_logs();
    trig_t.delete();
    trig_a.delete();
    trig_rs.delete();
    rsp_t.delete();
  endtask

  vec_t vt[4];

  initial begin
    int n, off, trig_off, rsp_off, idle_off, nrsp, ntrig, maxlvl;
    bit saw_stall, have;
    logic [15:0] rsp_val;
    logic        trig_rsv;
    logic [7:0]  trig_av;
    logic [15:0] trig_dv;
    req_t        pend;

    vt[0] = '{wr:1'b1, a:8'h12, d:16'hA5A5, rd:16'h0000, e_trig:2, e_rs:1'b0, e_rsp:-1, e_idle:7};
    vt[1] = '{wr:1'b0, a:8'h34, d:16'h0000, rd:16'hBEEF, e_trig:2, e_rs:1'b1, e_rsp:6,  e_idle:6};
    vt[2] = '{wr:1'b1, a:8'hFF, d:16'hFFFF, rd:16'h1234, e_trig:2, e_rs:1'b0, e_rsp:-1, e_idle:7};
    vt[3] = '{wr:1'b0, a:8'h00, d:16'h5A5A, rd:16'h0001, e_trig:2, e_rs:1'b1, e_rsp:6,  e_idle:6};

    bus.iReqValid = 1'b0;
    bus.iReqWrite = 1'b0;
    bus.iReqAddr  = '0;
    bus.iReqData  = '0;
    bus.iReadData = '0;
    model_en = 1'b0;
    t = 0;
    model_reset();
    Reset = 1'b1;

    // reset state
    @(negedge Clock);
    chk("rst_ready",   32'(bus.oReqReady), 32'd1);
    chk("rst_level",   32'(bus.oLevel),    32'd0);
    chk("rst_busy",    32'(bus.oBusy),     32'd0);
    chk("rst_trigger", 32'(bus.oTrigger),  32'd0);
    chk("rst_rsp",     32'(bus.oRspValid), 32'd0);
    chk("rst_addr",    32'(bus.oAddress),  32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    model_en = 1'b1;
    step();

    // directed single requests from an idle sequencer
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      clear_logs();
      bus.iReadData = vt[i].rd;
      bus.iReqValid = 1'b1;
      bus.iReqWrite = vt[i].wr;
      bus.iReqAddr  = vt[i].a;
      bus.iReqData  = vt[i].d;
      n = t;
      step();
      bus.iReqValid = 1'b0;
      trig_off = -1; rsp_off = -1; idle_off = -1; nrsp = 0; ntrig = 0;
      rsp_val = '0; trig_rsv = 1'b0; trig_av = '0; trig_dv = '0;
      for (int k = 0; k < 10; k++) begin
        step();
        off = t - 1 - n;
        if (s_trig) begin
          ntrig++;
          trig_off = off; trig_rsv = s_rs; trig_av = s_addr; trig_dv = s_dout;
        end
        if (s_rsp) begin
          nrsp++;
          rsp_off = off; rsp_val = s_rdata;
        end
        if (!s_busy && idle_off < 0) idle_off = off;
      end
      chk($sformatf("vec%0d_trig_cycle", i), 32'(trig_off), 32'(vt[i].e_trig));
      chk($sformatf("vec%0d_trig_count", i), 32'(ntrig), 32'd1);
      chk($sformatf("vec%0d_readsel", i), 32'(trig_rsv), 32'(vt[i].e_rs));
      chk($sformatf("vec%0d_addr", i), 32'(trig_av), 32'(vt[i].a));
      chk($sformatf("vec%0d_dout", i), 32'(trig_dv), 32'(vt[i].d));
      chk($sformatf("vec%0d_rsp_cycle", i), 32'(rsp_off), 32'(vt[i].e_rsp));
      chk($sformatf("vec%0d_rsp_count", i), 32'(nrsp), 32'(vt[i].e_rsp >= 0));
      if (!vt[i].wr) chk($sformatf("vec%0d_rsp_data", i), 32'(rsp_val), 32'(vt[i].rd));
      chk($sformatf("vec%0d_idle_cycle", i), 32'(idle_off), 32'(vt[i].e_idle));
    end

    // six back-to-back writes: fills the FIFO, last one held while full
    wait_idle();
    clear_logs();
    maxlvl = 0; saw_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.iReqValid = 1'b1;
      bus.iReqWrite = 1'b1;
      bus.iReqAddr  = 8'(8'h50 + i);
      bus.iReqData  = 16'(16'h1000 + i);
      step();
      if (32'(s_level) > maxlvl) maxlvl = 32'(s_level);
      for (int g = 0; g < 40 && !last_push; g++) begin
        if (!s_ready) saw_stall = 1'b1;
        step();
        if (32'(s_level) > maxlvl) maxlvl = 32'(s_level);
      end
      if (!last_push) chk("fill_push_timeout", 32'd1, 32'd0);
    end
    bus.iReqValid = 1'b0;
    wait_idle();
    chk("fill_max_level", 32'(maxlvl), 32'(DEPTH));
    chk("fill_saw_not_ready", 32'(saw_stall), 32'd1);
    chk("fill_trig_count", 32'(trig_t.size()), 32'd6);
    for (int i = 0; i < trig_t.size(); i++) begin
      chk($sformatf("fill_order%0d", i), 32'(trig_a[i]), 32'(8'h50 + i));
      if (i > 0) chk($sformatf("fill_spacing%0d", i), 32'(trig_t[i] - trig_t[i-1]), 32'(WCYC + 2));
    end

    // write then read of the same address
    clear_logs();
    bus.iReadData = 16'hC0DE;
    push_req(1'b1, 8'h40, 16'h7777);
    push_req(1'b0, 8'h40, 16'h0000);
    wait_idle();
    chk("wr_rd_trig_count", 32'(trig_t.size()), 32'd2);
    chk("wr_rd_rsp_count", 32'(rsp_t.size()), 32'd1);
    if (trig_t.size() == 2 && rsp_t.size() == 1) begin
      chk("wr_rd_spacing", 32'(trig_t[1] - trig_t[0]), 32'(WCYC + 2));
      chk("wr_rd_second_is_read", 32'(trig_rs[1]), 32'd1);
      chk("wr_rd_rsp_after_trig", 32'(rsp_t[0] - trig_t[1]), 32'(RCYC + 1));
    end

    // push during WAIT with one entry queued
    clear_logs();
    n = t;
    push_req(1'b0, 8'h60, 16'h0000);
    push_req(1'b1, 8'h61, 16'h2222);
    step();
    push_req(1'b1, 8'h62, 16'h3333);
    step();
    chk("wait_push_level", 32'(s_level), 32'd2);
    wait_idle();
    chk("wait_push_trig_count", 32'(trig_t.size()), 32'd3);
    if (trig_t.size() == 3) begin
      chk("wait_push_t0", 32'(trig_t[0] - n), 32'd2);
      chk("wait_push_t1", 32'(trig_t[1] - n), 32'(2 + RCYC + 2));
      chk("wait_push_t2", 32'(trig_t[2] - n), 32'(2 + RCYC + 2 + WCYC + 2));
    end

    // reset mid-WAIT of a read with two requests queued
    wait_idle();
    clear_logs();
    push_req(1'b0, 8'h70, 16'h0000);
    push_req(1'b1, 8'h71, 16'h1111);
    push_req(1'b1, 8'h72, 16'h2222);
    #2;
    Reset = 1'b1;
    model_en = 1'b0;
    @(negedge Clock);
    chk("rst_mid_level", 32'(bus.oLevel),    32'd0);
    chk("rst_mid_ready", 32'(bus.oReqReady), 32'd1);
    chk("rst_mid_rsp",   32'(bus.oRspValid), 32'd0);
    chk("rst_mid_busy",  32'(bus.oBusy),     32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    model_reset();
    model_en = 1'b1;
    t++;
    clear_logs();
    repeat (15) step();
    chk("rst_mid_no_trig", 32'(trig_t.size()), 32'd0);
    chk("rst_mid_no_rsp",  32'(rsp_t.size()),  32'd0);

    // randomized traffic against the model
    have = 1'b0;
    pend = '{wr:1'b0, a:8'h00, d:16'h0000};
    for (int c = 0; c < 1500; c++) begin
      if (!have && ($urandom_range(0, 2) != 0)) begin
        pend.wr = 1'($urandom);
        pend.a  = 8'($urandom);
        pend.d  = 16'($urandom);
        have = 1'b1;
      end
      bus.iReqValid = have;
      bus.iReqWrite = pend.wr;
      bus.iReqAddr  = pend.a;
      bus.iReqData  = pend.d;
      bus.iReadData = 16'($urandom);
      step();
      if (last_push) have = 1'b0;
    end
    bus.iReqValid = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
